// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder with a valid/ready handshake on both sides. A single
//   1-bit full adder is used for every bit, LSB first. The carry is kept in a
//   register between bits, so an operation takes WIDTH clocks in RUN.
//
// Ports
//   clk        : sole clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand set a/b/cin offered (taken only in IDLE)
//   in_ready   : high in IDLE
//   a, b       : WIDTH-bit operands (unsigned or two's complement)
//   cin        : carry into bit 0
//   out_valid  : high in DONE, result held until out_ready
//   out_ready  : consumer takes result (ignored outside DONE)
//   sum        : WIDTH-bit result, modulo 2^WIDTH, zero in IDLE
//   cout       : carry out of the MSB (unsigned overflow)
//   overflow   : signed overflow (carry into MSB xor carry out of MSB)
//   busy       : high in RUN
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic             w_last;

    // Operands shift right so the current bit is always at position 0; the
    // sum shifts in from the MSB, so after WIDTH steps bit[counter] of the
    // sum register holds the result of bit[counter]. This avoids a variable
    // index that would be degenerate for WIDTH=1.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // r_carry here is the carry into the MSB
                        r_cout  <= w_c;
                        r_ovf   <= r_carry ^ w_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No bypass: IDLE is entered first, acceptance happens
                    // at the following edge at the earliest.
                    if (out_ready) begin
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: one WIDTH=8 and one WIDTH=1 instance,
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       iv8, ir8, ov8, or8, co8, of8, bz8, cin8;
    logic [7:0] a8, b8, s8;

    logic       iv1, ir1, ov1, or1, co1, of1, bz1, cin1;
    logic [0:0] a1, b1, s1;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
        .overflow(of8), .busy(bz8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1),
        .overflow(of1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, cout, sum} for an 8-bit add
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    // Offer one operand set to an idle DUT, wait (bounded) for the result,
    // report latency, busy cycles and results, then hand the result off.
    task automatic run_op(input bit w1, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, output int lat, output int bcnt,
                          output logic [7:0] s, output logic co, output logic ov);
        if (w1) begin a1 = ta[0:0]; b1 = tb[0:0]; cin1 = tc; iv1 = 1'b1; end
        else    begin a8 = ta;      b8 = tb;      cin8 = tc; iv8 = 1'b1; end
        @(posedge clk); #1;
        iv1 = 1'b0; iv8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!(w1 ? ov1 : ov8) && lat < 40) begin
            if (w1 ? bz1 : bz8) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        s  = w1 ? {7'd0, s1} : s8;
        co = w1 ? co1 : co8;
        ov = w1 ? of1 : of8;
        or1 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0; or8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (ir8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir8); end
        total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov8); end
        total++; if (bz8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bz8); end
        total++; if (s8 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", s8); end
        total++; if (co8 !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", co8); end
        total++; if (of8 !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", of8); end
        total++; if ({ir1, ov1, bz1, s1} !== 4'b1000) begin bad++; $display("FAIL reset_w1 got=%b exp=1000", {ir1, ov1, bz1, s1}); end
    endtask

    task automatic test_directed;
        logic [7:0] ta [4] = '{8'h0F, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
        logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0] ex [4] = '{{2'b00, 8'h10}, {2'b01, 8'h01}, {2'b10, 8'h80}, {2'b11, 8'h00}};
        int lat, bc;
        logic [7:0] s;
        logic co, ov;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ta[i], tb[i], tc[i], lat, bc, s, co, ov);
            total++; if (lat !== 8) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=8", i, lat); end
            total++; if (bc !== 8) begin bad++; $display("FAIL dir%0d_busy got=%0d exp=8", i, bc); end
            total++; if ({ov, co, s} !== ex[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, {ov, co, s}, ex[i]); end
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [7:0] s, x, y;
        logic co, ov, c;
        logic [9:0] e;
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            e = model8(x, y, c);
            run_op(1'b0, x, y, c, lat, bc, s, co, ov);
            total++;
            if ({ov, co, s} !== e || lat !== 8) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h cin=%b got=%h lat=%0d exp=%h lat=8", i, x, y, c, {ov, co, s}, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        // keep offering a different operand set while busy
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
        total++; if (n !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", n); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s8 !== 8'h46 || ov8 !== 1'b1 || ir8 !== 1'b0 || co8 !== 1'b0 || of8 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got sum=%h ov=%b ir=%b exp sum=46 ov=1 ir=0", i, s8, ov8, ir8);
            end
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        total++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h00) begin bad++; $display("FAIL bp_idle got ir=%b ov=%b sum=%h exp ir=1 ov=0 sum=00", ir8, ov8, s8); end
        @(posedge clk); #1;
        iv8 = 1'b0;
        total++; if (bz8 !== 1'b1) begin bad++; $display("FAIL bp_next_accept got busy=%b exp=1", bz8); end
        n = 0;
        while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
        total++; if (s8 !== 8'hBB || n !== 8) begin bad++; $display("FAIL bp_next_result got=%h lat=%0d exp=bb lat=8", s8, n); end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int pulses, lat, bc;
        logic [7:0] s;
        logic co, ov;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({ir8, bz8, ov8, s8, co8, of8} !== {3'b100, 8'h00, 2'b00}) begin
            bad++;
            $display("FAIL midrst_state got ir=%b busy=%b ov=%b sum=%h co=%b of=%b exp 1 0 0 00 0 0", ir8, bz8, ov8, s8, co8, of8);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov8) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
        run_op(1'b0, 8'h01, 8'h02, 1'b1, lat, bc, s, co, ov);
        total++; if ({ov, co, s} !== 10'h004 || lat !== 8) begin bad++; $display("FAIL midrst_next got=%h lat=%0d exp=004 lat=8", {ov, co, s}, lat); end
    endtask

    task automatic test_width1;
        int lat, bc;
        logic [7:0] s;
        logic co, ov;
        logic [1:0] t;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            t = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            run_op(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], lat, bc, s, co, ov);
            total++;
            if (s[0] !== t[0] || co !== t[1] || ov !== (v[0] ^ t[1]) || lat !== 1 || bc !== 1) begin
                bad++;
                $display("FAIL w1_%0d got s=%b co=%b ov=%b lat=%0d exp s=%b co=%b ov=%b lat=1",
                         i, s[0], co, ov, lat, t[0], t[1], v[0] ^ t[1]);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_run;
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/cin offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in to bit 0.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  WIDTH  result bits.
REQ-012 SHALL have port cout  output  1  carry out of MSB (unsigned overflow).
REQ-013 SHALL have port overflow  output  1  signed overflow.
REQ-014 SHALL have port busy  output  1  high while in RUN.

Function
REQ-015 SHALL compute a+b+cin using one 1-bit full adder, one bit per clock, LSB first, carry held in a register between bits.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, busy=1 only in RUN, out_valid=1 only in DONE.
REQ-017 IDLE: on edge with in_valid=1, SHALL capture a, b, cin into internal registers, clear bit counter to 0, go RUN; in_valid=0 stays IDLE.
REQ-018 RUN: each edge SHALL write full-adder sum of bit[counter] into sum register bit[counter], update carry register, increment counter.
REQ-019 RUN: on the edge processing bit WIDTH-1, SHALL set cout = carry out of that bit, overflow = carry into MSB XOR carry out of MSB, go DONE.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH edges after the acceptance edge (8 for WIDTH=8, 1 for WIDTH=1).
REQ-021 DONE: sum, cout, overflow, out_valid SHALL hold stable until an edge with out_ready=1, then go IDLE.
REQ-022 No bypass: SHALL NOT accept new operands on the same edge as result handoff; earliest next acceptance is the following edge.
REQ-023 in_valid, a, b, cin changes during RUN or DONE SHALL be ignored and SHALL NOT disturb the computation.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 WIDTH=1: overflow SHALL equal cin XOR cout (carry into MSB is cin).
REQ-026 Arithmetic SHALL be modulo 2^WIDTH for sum; no internal signal wider than WIDTH+1 bits.
REQ-027 sum SHALL be 0 in IDLE; outputs only meaningful while out_valid=1.

Reset
REQ-028 With rst_n=0 at an edge, SHALL enter IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; reset SHALL take priority over every other event at that edge.

Verification
REQ-030 Reset: rst_n=0 two cycles, then 1 -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0, overflow=0.
REQ-031 WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, overflow=0; out_valid high exactly 8 edges after acceptance; busy high 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, overflow=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1.
REQ-033 Backpressure: result a=0x12, b=0x34 held with out_ready=0 five cycles -> sum=0x46 stable, out_valid=1, in_ready=0; new in_valid=1 with a=0xAA during RUN/DONE ignored; after out_ready=1 edge, IDLE, next op accepted one edge later.
REQ-034 Reset mid-RUN after bit 3 of a=0xFF, b=0xFF -> IDLE next edge, all outputs 0, no out_valid; following op a=0x01, b=0x02, cin=1 -> sum=0x04, cout=0, overflow=0.
REQ-035 WIDTH=1 instance: a=1, b=1, cin=1 -> sum=1, cout=1, overflow=0, out_valid 1 edge after acceptance; exhaustive 8 combinations match a+b+cin.
